// File: rtl/iir_pkg.sv
// Shared constants, types and saturation helper for the look-ahead IIR coefficient path.
package iir_pkg;

  localparam int unsigned NB   = 13;
  localparam int unsigned FRAC = NB - 1;
  localparam int unsigned PW   = 2 * NB;

  typedef logic signed [NB-1:0] coeff_t;
  typedef logic signed [PW-1:0] prod_t;

  typedef enum logic [2:0] {
    IDLE,
    MUL1,
    MUL2,
    MUL3,
    SUB,
    COMMIT
  } state_t;

  // Clamp a wide signed value into the Q1.(NB-1) coefficient range.
  function automatic coeff_t sat_nb(input prod_t x);
    prod_t hi;
    prod_t lo;
    hi = '0;
    hi[NB-2:0] = '1;
    lo = '1;
    lo[NB-2:0] = '0;
    if (x > hi) begin
      sat_nb = hi[NB-1:0];
    end else if (x < lo) begin
      sat_nb = lo[NB-1:0];
    end else begin
      sat_nb = x[NB-1:0];
    end
  endfunction

endpackage

// File: rtl/iir_coeff_prep_if.sv
// Raw-coefficient request and committed look-ahead coefficient bus.
interface iir_coeff_prep_if;
  import iir_pkg::*;

  logic   START;
  coeff_t A1_IN;
  coeff_t B0_IN;
  coeff_t B1_IN;
  coeff_t A1_2;
  coeff_t B0;
  coeff_t B1_A1B0;
  coeff_t A1B1;
  logic   VALID;
  logic   BUSY;
  logic   DONE;

  modport master (
    output START, A1_IN, B0_IN, B1_IN,
    input  A1_2, B0, B1_A1B0, A1B1, VALID, BUSY, DONE
  );

  modport slave (
    input  START, A1_IN, B0_IN, B1_IN,
    output A1_2, B0, B1_A1B0, A1B1, VALID, BUSY, DONE
  );

endinterface

// File: rtl/iir_sat_mul.sv
// Combinational fixed-point multiply: full product, floor shift by FRAC, saturate to NB.
module iir_sat_mul
  import iir_pkg::*;
(
  input  coeff_t a,
  input  coeff_t b,
  output coeff_t p_c
);

  prod_t full;
  prod_t shifted;

  always_comb begin
    full    = PW'(a) * PW'(b);
    shifted = full >>> FRAC;
    p_c     = sat_nb(shifted);
  end

endmodule

// File: rtl/iir_coeff_prep.sv
// Computes look-ahead IIR coefficients with one shared multiplier and commits them atomically.
module iir_coeff_prep
  import iir_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_n,
  iir_coeff_prep_if.slave   bus
);

  state_t state;
  coeff_t a1;
  coeff_t b0;
  coeff_t b1;
  coeff_t p_aa;
  coeff_t p_ab0;
  coeff_t p_ab1;
  coeff_t mul_b_c;
  coeff_t mul_p_c;
  coeff_t diff_sat_c;
  logic signed [NB:0] diff_c;

  // Second multiplier operand follows the sequencing state; a1 is always the first.
  always_comb begin
    mul_b_c = a1;
    case (state)
      MUL2:    mul_b_c = b0;
      MUL3:    mul_b_c = b1;
      default: mul_b_c = a1;
    endcase
  end

  iir_sat_mul u_mul (
    .a   (a1),
    .b   (mul_b_c),
    .p_c (mul_p_c)
  );

  always_comb begin
    diff_c     = (NB+1)'(b1) - (NB+1)'(p_ab0);
    diff_sat_c = sat_nb(PW'(diff_c));
  end

  // Outputs are only written on the SUB->COMMIT edge, so a mixed set is never visible.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state       <= IDLE;
      a1          <= '0;
      b0          <= '0;
      b1          <= '0;
      p_aa        <= '0;
      p_ab0       <= '0;
      p_ab1       <= '0;
      bus.A1_2    <= '0;
      bus.B0      <= '0;
      bus.B1_A1B0 <= '0;
      bus.A1B1    <= '0;
      bus.VALID   <= 1'b0;
      bus.BUSY    <= 1'b0;
      bus.DONE    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.START) begin
            a1       <= bus.A1_IN;
            b0       <= bus.B0_IN;
            b1       <= bus.B1_IN;
            bus.BUSY <= 1'b1;
            state    <= MUL1;
          end
        end
        MUL1: begin
          p_aa  <= mul_p_c;
          state <= MUL2;
        end
        MUL2: begin
          p_ab0 <= mul_p_c;
          state <= MUL3;
        end
        MUL3: begin
          p_ab1 <= mul_p_c;
          state <= SUB;
        end
        SUB: begin
          bus.A1_2    <= p_aa;
          bus.B0      <= b0;
          bus.B1_A1B0 <= diff_sat_c;
          bus.A1B1    <= p_ab1;
          bus.VALID   <= 1'b1;
          bus.BUSY    <= 1'b0;
          bus.DONE    <= 1'b1;
          state       <= COMMIT;
        end
        COMMIT: begin
          bus.DONE <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.BUSY <= 1'b0;
          bus.DONE <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
